prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the `memory_block` BRAM (port A) and lets a host download 6502 code and data into the 64 KiB address space without rebuilding the block RAM init file. It parses framed bytes from a serial receiver: sync byte, 16-bit start address, 16-bit length, payload. It issues one single-cycle BRAM write per payload byte. While a frame is in progress it holds the processor off the bus.

---
 rtl/prog_loader_pkg.sv | 32 +++
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared types and constants for the byte-stream program
//                loader (state encoding, default sync byte, header size).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package prog_loader_pkg;

   // Loader frame-parsing states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      LEN_HI  = 3'd3,
      LEN_LO  = 3'd4,
      DATA    = 3'd5,
      CHK     = 3'd6,
      DONE    = 3'd7
   } loader_state_t;

   // Frame start marker used when the instantiating design does not override it
   localparam logic [7:0] LOADER_SYNC_DEFAULT = 8'hA5;

   // Header bytes between the sync byte and the payload: addr hi/lo, len hi/lo
   localparam int LOADER_HDR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Parses framed bytes (sync, 16-bit start address, 16-bit
//                length, payload) and writes each payload byte into BRAM
//                port A, holding the CPU off the bus while a frame is open.
//                Optional XOR checksum byte after the payload is enabled by
//                defining PROG_LOADER_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE  = LOADER_SYNC_DEFAULT,
   parameter int         ADDR_WIDTH = 16
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   loader_state_t         state;
   logic [7:0]            addr_hi_q;
   logic [7:0]            len_hi_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           cnt_q;
   logic                  accept;
   logic [15:0]           len_w;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q;
`else
   // No checksum byte exists in this build, so a frame can never fail
   assign error = 1'b0;
`endif

   assign accept = rx_valid && rx_ready;
   assign len_w  = {len_hi_q, rx_data};

   // Frame parser FSM with registered BRAM-port, handshake and status outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= IDLE;
         addr_hi_q <= 8'h00;
         len_hi_q  <= 8'h00;
         addr_q    <= '0;
         cnt_q     <= 16'h0000;
         rx_ready  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         cpu_hold  <= 1'b0;
         done      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q    <= 8'h00;
         error     <= 1'b0;
`endif
      end else begin
         // Strobes default low; ready stays high unless DONE is entered
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
         rx_ready <= 1'b1;

         case (state)
            IDLE: begin
               if (accept && rx_data == SYNC_BYTE) begin
                  state    <= ADDR_HI;
                  cpu_hold <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_q   <= 8'h00;
                  error    <= 1'b0;
`endif
               end
            end

            ADDR_HI: begin
               if (accept) begin
                  addr_hi_q <= rx_data;
                  state     <= ADDR_LO;
               end
            end

            ADDR_LO: begin
               if (accept) begin
                  addr_q <= ADDR_WIDTH'({addr_hi_q, rx_data});
                  state  <= LEN_HI;
               end
            end

            LEN_HI: begin
               if (accept) begin
                  len_hi_q <= rx_data;
                  state    <= LEN_LO;
               end
            end

            LEN_LO: begin
               if (accept) begin
                  cnt_q <= len_w;
                  if (len_w != 16'h0000) begin
                     state <= DATA;
                  end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     state <= CHK;
`else
                     state    <= DONE;
                     done     <= 1'b1;
                     rx_ready <= 1'b0;
`endif
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= rx_data;
                  addr_q    <= addr_q + ADDR_WIDTH'(1);
                  cnt_q     <= cnt_q - 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_q    <= csum_q ^ rx_data;
`endif
                  // The byte that takes the count to zero closes the payload
                  if (cnt_q == 16'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     state <= CHK;
`else
                     state    <= DONE;
                     done     <= 1'b1;
                     rx_ready <= 1'b0;
`endif
                  end
               end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  state    <= DONE;
                  rx_ready <= 1'b0;
                  // A mismatch still walks through DONE, just without the pulse
                  if (rx_data == csum_q) begin
                     done <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
`endif

            DONE: begin
               state    <= IDLE;
               cpu_hold <= 1'b0;
            end

            default: begin
               state    <= IDLE;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Directed, table-driven bench for prog_loader with a BRAM
//                model and a write/done monitor. Checksum vectors are built
//                in when PROG_LOADER_CHECKSUM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk_sys  = 1'b0;
   logic        reset    = 1'b1;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   prog_loader #(.SYNC_BYTE(8'hA5), .ADDR_WIDTH(16)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // BRAM port A model
   logic [7:0] bram [0:65535];
   always @(posedge clk_sys) begin
      if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
   end

   // Monitor: record writes, done pulses and hold cycles
   int          cyc = 0;
   logic [15:0] wa_q [$];
   logic [7:0]  wd_q [$];
   int          wc_q [$];
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          hold_cyc = 0;

   always @(negedge clk_sys) begin
      cyc = cyc + 1;
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
         wc_q.push_back(cyc);
         check("we_implies_en", {31'd0, mem_en}, 32'd1);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         check("rx_ready_low_in_done", {31'd0, rx_ready}, 32'd0);
      end
      if (cpu_hold) hold_cyc = hold_cyc + 1;
   end

   // Stimulus and expectation tables
   typedef struct {
      int   s_start;
      int   s_len;
      int   w_start;
      int   w_len;
      int   sync_idx;
      int   n_done;
      logic err;
   } vec_t;

   logic [7:0]  stim  [$];
   logic [15:0] exp_a [$];
   logic [7:0]  exp_d [$];
   vec_t        vecs  [$];

   // Bytes are right-aligned in b; byte 0 is the most significant of the n
   task automatic add_stim(input logic [127:0] b, input int n);
      for (int i = 0; i < n; i++) stim.push_back(b[8*(n-1-i) +: 8]);
   endtask

   task automatic add_vec(input logic [127:0] b, input int n, input logic [7:0] chk,
                          input int sync_idx, input int ndone, input logic err,
                          input logic [15:0] wbase, input logic [63:0] wbytes, input int nw);
      vec_t v;
      v.s_start  = stim.size();
      add_stim(b, n);
      if (CK) stim.push_back(chk);
      v.s_len    = stim.size() - v.s_start;
      v.w_start  = exp_a.size();
      for (int i = 0; i < nw; i++) begin
         exp_a.push_back(wbase + 16'(i));
         exp_d.push_back(wbytes[8*(nw-1-i) +: 8]);
      end
      v.w_len    = nw;
      v.sync_idx = sync_idx;
      v.n_done   = ndone;
      v.err      = err;
      vecs.push_back(v);
   endtask

   task automatic send(input int start, input int len);
      for (int i = 0; i < len; i++) begin
         int tries = 0;
         forever begin
            @(negedge clk_sys);
            rx_data  = stim[start + i];
            rx_valid = 1'b1;
            if (rx_ready) break;
            tries++;
            if (tries > 20) begin
               check("rx_ready_timeout", 32'd0, 32'd1);
               break;
            end
         end
      end
      @(negedge clk_sys);
      rx_valid = 1'b0;
   endtask

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      done_cnt = 0;
      done_cyc = -1;
      hold_cyc = 0;
   endtask

   task automatic run_vec(input int k);
      vec_t v;
      int   nw;
      v = vecs[k];
      clear_mon();
      send(v.s_start, v.s_len);
      repeat (4) @(negedge clk_sys);
      nw = wa_q.size();
      check($sformatf("v%0d_nwrites", k), nw, v.w_len);
      for (int i = 0; i < nw && i < v.w_len; i++) begin
         check($sformatf("v%0d_waddr%0d", k, i), {16'd0, wa_q[i]}, {16'd0, exp_a[v.w_start + i]});
         check($sformatf("v%0d_wdata%0d", k, i), {24'd0, wd_q[i]}, {24'd0, exp_d[v.w_start + i]});
         check($sformatf("v%0d_bram%0d", k, i), {24'd0, bram[exp_a[v.w_start + i]]},
               {24'd0, exp_d[v.w_start + i]});
         if (i > 0) check($sformatf("v%0d_b2b%0d", k, i), wc_q[i] - wc_q[i-1], 32'd1);
      end
      check($sformatf("v%0d_done_cnt", k), done_cnt, v.n_done);
      check($sformatf("v%0d_error", k), {31'd0, error}, {31'd0, v.err});
      check($sformatf("v%0d_hold_cycles", k), hold_cyc, v.s_len - v.sync_idx);
      check($sformatf("v%0d_hold_released", k), {31'd0, cpu_hold}, 32'd0);
      if (nw > 0 && done_cnt == 1)
         check($sformatf("v%0d_done_timing", k), done_cyc - wc_q[nw-1], CK ? 32'd1 : 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd0);
      check({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
      check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
      check({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
      check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
      check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd0);
      check({tag, "_done"},      {31'd0, done},      32'd0);
      check({tag, "_error"},     {31'd0, error},     32'd0);
   endtask

   initial begin
      int n_main;
      int rst_start;
      int post_idx;
      int tail_start;

      // Main frames: bytes, checksum byte, sync index, done count, error, writes
      add_vec(128'hA5020000_03112233, 8, 8'h00, 0, 1, 1'b0, 16'h0200, 64'h112233, 3);
      add_vec(128'h00FFA501_0000017E, 8, 8'h7E, 2, 1, 1'b0, 16'h0100, 64'h7E, 1);
      add_vec(128'hA5FFFF_0002AABB,   7, 8'h11, 0, 1, 1'b0, 16'hFFFF, 64'hAABB, 2);
      add_vec(128'hA5123400_00,       5, 8'h00, 0, 1, 1'b0, 16'h0000, 64'h0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      add_vec(128'hA5001000_020FF0,   7, 8'hFF, 0, 1, 1'b0, 16'h0010, 64'h0FF0, 2);
      add_vec(128'hA5001000_020FF0,   7, 8'h00, 0, 0, 1'b1, 16'h0010, 64'h0FF0, 2);
`endif
      n_main = vecs.size();

      // Frame cut by reset after two of four payload bytes
      rst_start = stim.size();
      add_stim(128'hA5300000_040102, 7);

      // Frame loaded after the reset recovery
      post_idx = vecs.size();
      add_vec(128'hA5400000_015C, 6, 8'h5C, 0, 1, 1'b0, 16'h4000, 64'h5C, 1);

      // Sync-only opener then the rest of a zero-length frame
      tail_start = stim.size();
      add_stim(128'hA5_50000000_00, 6);

      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      reset = 1'b0;

      for (int k = 0; k < n_main; k++) run_vec(k);

`ifdef PROG_LOADER_CHECKSUM_EN
      // A new sync alone clears the sticky error left by the bad frame
      check("err_before_sync", {31'd0, error}, 32'd1);
      clear_mon();
      send(tail_start, 1);
      check("err_cleared_by_sync", {31'd0, error}, 32'd0);
      check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
      send(tail_start + 1, 5);
      repeat (4) @(negedge clk_sys);
      check("tail_done_cnt", done_cnt, 32'd1);
      check("tail_hold_released", {31'd0, cpu_hold}, 32'd0);
`endif

      // Reset mid-frame
      clear_mon();
      send(rst_start, 7);
      reset = 1'b1;
      @(negedge clk_sys);
      check_reset_outputs("midreset");
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("midreset_nwrites", wa_q.size(), 32'd2);
      check("midreset_no_done", done_cnt, 32'd0);
      check("midreset_bram0", {24'd0, bram[16'h3000]}, 32'h01);
      check("midreset_bram1", {24'd0, bram[16'h3001]}, 32'h02);
      check("midreset_hold", {31'd0, cpu_hold}, 32'd0);

      run_vec(post_idx);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      check("global_timeout", 32'd0, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
